// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills a 2-entry prefetch queue from
// combinational instruction memory and presents the head to decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [CNT_W-1:0]    count_q;
  logic [INSTR_W-1:0]  q_instr [2];
  logic [ADDR_W-1:0]   q_pc    [2];

  logic                pop_c;
  logic                push_c;
  logic                wr_idx_c;
  logic [ADDR_W-1:0]   redirect_tgt_c;

  // Redirect targets are always halfword aligned.
  assign redirect_tgt_c = redirect_pc & ~ADDR_W'(1);

  assign imem_addr = pc_q;
  assign out_valid = (count_q != CNT_W'(0));
  assign out_instr = q_instr[0];
  assign out_pc    = q_pc[0];
  assign halted    = (state_q == HALTED);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, push/pop decisions and tail slot selection.
  always_comb begin
    state_d  = state_q;
    pop_c    = out_valid & out_ready;
    push_c   = 1'b0;
    wr_idx_c = 1'(count_q - {1'b0, pop_c});
    case (state_q)
      FETCH: begin
        push_c = !halt_req && !redirect_valid &&
                 ((count_q != CNT_W'(2)) || pop_c);
        if (halt_req && !redirect_valid) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          state_d = FETCH;
        end
      end
    endcase
  end

  // PC, occupancy and queue storage; a pop shifts slot 1 into the head and a
  // same-cycle push into slot 0 overrides that shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= ADDR_W'(RESET_PC);
      count_q    <= '0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q <= redirect_tgt_c;
      end else if (push_c) begin
        pc_q <= pc_q + ADDR_W'(PC_STEP);
      end

      if (redirect_valid) begin
        count_q <= '0;
      end else begin
        case ({push_c, pop_c})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end

      if (pop_c) begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      if (push_c) begin
        q_instr[wr_idx_c] <= imem_instr;
        q_pc[wr_idx_c]    <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected queue entries plus a table of
// stimulus phases with hand-derived end-of-phase values.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [6:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [6:0]  out_pc;
  logic        redirect_valid;
  logic [6:0]  redirect_pc;
  logic        halt_req;
  logic        halted;

  logic [6:0]  w_imem_addr;
  logic [31:0] w_imem_instr;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [6:0]  w_out_pc;
  logic        w_halted;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  pc;
  } ent_t;

  typedef struct {
    int         ncyc;
    logic       rdy;
    logic       redir;
    logic       halt;
    logic [6:0] rpc;
    logic       exp_valid;
    logic [6:0] exp_pc;
    logic       exp_halted;
    logic [6:0] exp_addr;
    string      nm;
  } row_t;

  ent_t       sb[$];
  logic [6:0] m_pc;
  logic       m_halted;
  int         n_tests;
  int         n_fail;
  int         cyc;
  row_t       tbl[16];
  logic [6:0] wrap_exp[4];

  function automatic logic [31:0] imem_f(logic [6:0] a);
    return {a, 18'h2A5A5, a};
  endfunction

  assign imem_instr   = imem_f(imem_addr);
  assign w_imem_instr = imem_f(w_imem_addr);

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted)
  );

  fetch_unit #(.RESET_PC('h7C)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .redirect_valid(1'b0), .redirect_pc(7'h00),
    .halt_req(1'b0), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic row_t mk(int n, logic rdy, logic redir, logic halt,
                              logic [6:0] rpc, logic ev, logic [6:0] epc,
                              logic eh, logic [6:0] ea, string nm);
    row_t r;
    r.ncyc = n; r.rdy = rdy; r.redir = redir; r.halt = halt; r.rpc = rpc;
    r.exp_valid = ev; r.exp_pc = epc; r.exp_halted = eh; r.exp_addr = ea;
    r.nm = nm;
    return r;
  endfunction

  // One clock: advance the model with the inputs currently applied, then
  // compare the DUT on the following falling edge.
  task automatic tick();
    logic pop_m;
    logic push_m;
    ent_t e;
    pop_m  = (sb.size() != 0) && out_ready;
    push_m = !m_halted && !halt_req && !redirect_valid && ((sb.size() < 2) || pop_m);
    if (pop_m) void'(sb.pop_front());
    if (redirect_valid) begin
      sb.delete();
      m_pc     = redirect_pc & 7'h7E;
      m_halted = 1'b0;
    end else begin
      if (push_m) begin
        e.instr = imem_f(m_pc);
        e.pc    = m_pc;
        sb.push_back(e);
        m_pc = m_pc + 7'd2;
      end
      if (!m_halted && halt_req) m_halted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("sb_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("sb_imem_addr", 32'(imem_addr), 32'(m_pc));
    check("sb_halted", 32'(halted), 32'(m_halted));
    if (sb.size() != 0) begin
      check("sb_head_pc", 32'(out_pc), 32'(sb[0].pc));
      check("sb_head_instr", out_instr, sb[0].instr);
    end
    if (cyc <= 4) begin
      check("wrap_valid", 32'(w_out_valid), 32'(1));
      check("wrap_pc", 32'(w_out_pc), 32'(wrap_exp[cyc-1]));
      check("wrap_instr", w_out_instr, imem_f(wrap_exp[cyc-1]));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    wrap_exp[0] = 7'h7C; wrap_exp[1] = 7'h7E; wrap_exp[2] = 7'h00; wrap_exp[3] = 7'h02;

    tbl[0]  = mk(4, 1, 0, 0, 7'h00, 1, 7'h06, 0, 7'h08, "stream");
    tbl[1]  = mk(5, 0, 0, 0, 7'h00, 1, 7'h06, 0, 7'h0A, "stall_full");
    tbl[2]  = mk(3, 1, 0, 0, 7'h00, 1, 7'h0C, 0, 7'h10, "release");
    tbl[3]  = mk(2, 0, 0, 0, 7'h00, 1, 7'h0C, 0, 7'h10, "hold_full");
    tbl[4]  = mk(1, 0, 1, 0, 7'h21, 0, 7'h00, 0, 7'h20, "redirect_flush");
    tbl[5]  = mk(1, 0, 0, 0, 7'h00, 1, 7'h20, 0, 7'h22, "redirect_target");
    tbl[6]  = mk(1, 0, 0, 0, 7'h00, 1, 7'h20, 0, 7'h24, "refill");
    tbl[7]  = mk(1, 0, 0, 1, 7'h00, 1, 7'h20, 1, 7'h24, "halt_full");
    tbl[8]  = mk(3, 1, 0, 0, 7'h00, 0, 7'h00, 1, 7'h24, "halt_drain");
    tbl[9]  = mk(2, 1, 0, 1, 7'h00, 0, 7'h00, 1, 7'h24, "halt_ignored");
    tbl[10] = mk(1, 1, 1, 0, 7'h10, 0, 7'h00, 0, 7'h10, "unhalt_redirect");
    tbl[11] = mk(1, 1, 0, 0, 7'h00, 1, 7'h10, 0, 7'h12, "unhalt_target");
    tbl[12] = mk(1, 1, 0, 0, 7'h00, 1, 7'h12, 0, 7'h14, "unhalt_next");
    tbl[13] = mk(1, 1, 1, 1, 7'h41, 0, 7'h00, 0, 7'h40, "redirect_beats_halt");
    tbl[14] = mk(1, 1, 0, 0, 7'h00, 1, 7'h40, 0, 7'h42, "after_redirect_pop");
    tbl[15] = mk(1, 1, 0, 1, 7'h00, 0, 7'h00, 1, 7'h42, "halt_while_popping");

    out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    reset = 1'b1;
    m_pc = 7'h00; m_halted = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_pc", 32'(out_pc), 32'(0));
    check("rst_instr", out_instr, 32'h0);
    check("rst_imem_addr", 32'(imem_addr), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_wrap_addr", 32'(w_imem_addr), 32'h7C);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      out_ready      = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      halt_req       = tbl[i].halt;
      repeat (tbl[i].ncyc) tick();
      check({tbl[i].nm, "_valid"}, 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check({tbl[i].nm, "_pc"}, 32'(out_pc), 32'(tbl[i].exp_pc));
      check({tbl[i].nm, "_halted"}, 32'(halted), 32'(tbl[i].exp_halted));
      check({tbl[i].nm, "_addr"}, 32'(imem_addr), 32'(tbl[i].exp_addr));
    end

    // Restart a stream, then hit it with reset between clock edges.
    out_ready = 1'b1; halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 7'h30;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check("pre_async_pc", 32'(out_pc), 32'h34);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'(0));
    check("async_pc", 32'(out_pc), 32'(0));
    check("async_instr", out_instr, 32'h0);
    check("async_imem_addr", 32'(imem_addr), 32'(0));
    check("async_halted", 32'(halted), 32'(0));
    sb.delete(); m_pc = 7'h00; m_halted = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("restart_pc0", 32'(out_pc), 32'(0));
    repeat (3) tick();
    check("restart_pc3", 32'(out_pc), 32'h06);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
